// File: rtl/issue_ctrl.sv
// issue_ctrl: single-issue sequencer with branch hold, load-use stall and data-memory handshake.
// Optional feature macro ISSUE_MEM_TIMEOUT_EN: aborts MEM_WAIT after MEM_TIMEOUT cycles with a mem_err pulse.
`ifndef MemDoNothing
`define MemDoNothing 3'b000
`endif

module issue_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rs2_used,
  input  logic [4:0]       dec_rd,
  input  logic             dec_rd_wen,
  input  logic             dec_branch,
  input  logic [2:0]       dec_mem_opcode,
  input  logic             dec_mem_load,
  input  logic             br_done,
  input  logic             br_taken,
  output logic             mem_req,
  output logic [2:0]       mem_op,
  input  logic             mem_ready,
  output logic             mem_err,
  output logic             fetch_en,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LDWB     = 2'd1,
    BR_WAIT  = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             ld_r, ld_nxt_s;
  logic [4:0]       ld_rd_r, ld_rd_nxt_s;
  logic [2:0]       mem_op_r, mem_op_nxt_s;
  logic             mem_req_r;
  logic             flush_r, flush_nxt_s;
  logic             mem_err_r, mem_err_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             hazard_s, ready_s, issue_s, tmo_hit_s;

`ifdef ISSUE_MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_r;

  // Timeout count is held at zero outside MEM_WAIT, so it restarts on every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r == MEM_WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= 8'd0;
    end
  end

  assign tmo_hit_s = (state_r == MEM_WAIT) && (tmo_cnt_r == 8'(MEM_TIMEOUT - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  assign hazard_s = (state_r == LDWB) && (ld_rd_r != 5'd0) &&
                    ((dec_rs1 == ld_rd_r) || (dec_rs2_used && (dec_rs2 == ld_rd_r)));
  assign ready_s  = ((state_r == RUN) || (state_r == LDWB)) && !hazard_s && !flush_r;
  assign issue_s  = dec_valid && ready_s;

  // Next-state and next-register-value logic
  always_comb begin
    state_nxt_s   = state_r;
    ld_nxt_s      = ld_r;
    ld_rd_nxt_s   = ld_rd_r;
    mem_op_nxt_s  = mem_op_r;
    flush_nxt_s   = 1'b0;
    mem_err_nxt_s = 1'b0;
    case (state_r)
      RUN, LDWB: begin
        if (!issue_s) begin
          state_nxt_s = RUN;
          ld_nxt_s    = 1'b0;
          ld_rd_nxt_s = 5'd0;
        end else if (dec_branch) begin
          state_nxt_s = BR_WAIT;
          ld_nxt_s    = 1'b0;
          ld_rd_nxt_s = 5'd0;
        end else if (dec_mem_opcode != `MemDoNothing) begin
          state_nxt_s  = MEM_WAIT;
          mem_op_nxt_s = dec_mem_opcode;
          ld_nxt_s     = dec_mem_load & dec_rd_wen;
          ld_rd_nxt_s  = dec_rd;
        end else begin
          state_nxt_s = RUN;
          ld_nxt_s    = 1'b0;
          ld_rd_nxt_s = 5'd0;
        end
      end
      BR_WAIT: begin
        if (br_done) begin
          state_nxt_s = RUN;
          flush_nxt_s = br_taken;
        end else begin
          state_nxt_s = BR_WAIT;
        end
      end
      MEM_WAIT: begin
        // A completion in the timeout cycle still counts as a normal completion
        if (mem_ready) begin
          mem_op_nxt_s = `MemDoNothing;
          ld_nxt_s     = 1'b0;
          if (ld_r && (ld_rd_r != 5'd0)) begin
            state_nxt_s = LDWB;
          end else begin
            state_nxt_s = RUN;
            ld_rd_nxt_s = 5'd0;
          end
        end else if (tmo_hit_s) begin
          state_nxt_s   = RUN;
          mem_op_nxt_s  = `MemDoNothing;
          ld_nxt_s      = 1'b0;
          ld_rd_nxt_s   = 5'd0;
          mem_err_nxt_s = 1'b1;
        end else begin
          state_nxt_s = MEM_WAIT;
        end
      end
      default: begin
        state_nxt_s  = RUN;
        ld_nxt_s     = 1'b0;
        ld_rd_nxt_s  = 5'd0;
        mem_op_nxt_s = `MemDoNothing;
      end
    endcase
  end

  // State, handshake outputs and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      ld_r        <= 1'b0;
      ld_rd_r     <= 5'd0;
      mem_op_r    <= `MemDoNothing;
      mem_req_r   <= 1'b0;
      flush_r     <= 1'b0;
      mem_err_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      ld_r      <= ld_nxt_s;
      ld_rd_r   <= ld_rd_nxt_s;
      mem_op_r  <= mem_op_nxt_s;
      mem_req_r <= (state_nxt_s == MEM_WAIT);
      flush_r   <= flush_nxt_s;
      mem_err_r <= mem_err_nxt_s;
      if (dec_valid && !ready_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign dec_ready = ready_s;
  assign fetch_en  = ready_s;
  assign mem_req   = mem_req_r;
  assign mem_op    = mem_op_r;
  assign flush     = flush_r;
  assign mem_err   = mem_err_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: the driver pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_issue_ctrl;

  localparam logic [2:0] NOP_OP = 3'b000;
  localparam logic [2:0] LD_OP  = 3'b001;
  localparam logic [2:0] ST_OP  = 3'b010;
`ifdef ISSUE_MEM_TIMEOUT_EN
  localparam int ST_WAIT = 3;
`else
  localparam int ST_WAIT = 5;
`endif

  logic        clk, rst_n;
  logic        dec_valid, dec_ready, dec_rs2_used, dec_rd_wen, dec_branch, dec_mem_load;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [2:0]  dec_mem_opcode, mem_op;
  logic        br_done, br_taken, mem_req, mem_ready, mem_err, fetch_en, flush;
  logic [31:0] stall_cnt;

  issue_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_wen(dec_rd_wen), .dec_branch(dec_branch),
    .dec_mem_opcode(dec_mem_opcode), .dec_mem_load(dec_mem_load),
    .br_done(br_done), .br_taken(br_taken),
    .mem_req(mem_req), .mem_op(mem_op), .mem_ready(mem_ready), .mem_err(mem_err),
    .fetch_en(fetch_en), .flush(flush), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string       tag;
    logic        rdy;
    logic        req;
    logic [2:0]  op;
    logic        fl;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the oldest expectation against the DUT mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (dec_ready !== e.rdy || fetch_en !== e.rdy || mem_req !== e.req || mem_op !== e.op ||
          flush !== e.fl || mem_err !== e.err || stall_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: got rdy=%b fe=%b req=%b op=%b fl=%b err=%b cnt=%0d, want rdy=%b req=%b op=%b fl=%b err=%b cnt=%0d",
                 e.tag, dec_ready, fetch_en, mem_req, mem_op, flush, mem_err, stall_cnt,
                 e.rdy, e.req, e.op, e.fl, e.err, e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic rs2u,
                     input logic [4:0] rd, input logic rdw, input logic br, input logic [2:0] mop,
                     input logic ld, input logic bd, input logic bt, input logic mr);
    dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_rs2_used = rs2u;
    dec_rd = rd; dec_rd_wen = rdw; dec_branch = br; dec_mem_opcode = mop;
    dec_mem_load = ld; br_done = bd; br_taken = bt; mem_ready = mr;
  endtask

  task automatic alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic rs2u,
                     input logic bd, input logic bt, input logic mr);
    drv(1'b1, rs1, rs2, rs2u, 5'd9, 1'b1, 1'b0, NOP_OP, 1'b0, bd, bt, mr);
  endtask

  task automatic idle(input logic mr);
    drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, NOP_OP, 1'b0, 1'b0, 1'b0, mr);
  endtask

  task automatic mem_issue(input logic [2:0] mop, input logic ld, input logic [4:0] rd);
    drv(1'b1, 5'd0, 5'd0, 1'b0, rd, ld, 1'b0, mop, ld, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_c(input string tag, input logic rdy, input logic req, input logic [2:0] op,
                          input logic fl, input logic err, input int cnt);
    exp_t x;
    x.tag = tag; x.rdy = rdy; x.req = req; x.op = op; x.fl = fl; x.err = err; x.cnt = 32'(cnt);
    exp_q.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(1'b0);
    #2;
    expect_c("reset", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 0);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_c("alu_stream", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 0);
    end

    // Taken branch resolved three cycles after issue
    tick(); drv(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, NOP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_c("br_issue", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 0);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("br_wait1", 1'b0, 1'b0, NOP_OP, 1'b0, 1'b0, 0);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("br_wait2", 1'b0, 1'b0, NOP_OP, 1'b0, 1'b0, 1);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_c("br_done_t", 1'b0, 1'b0, NOP_OP, 1'b0, 1'b0, 2);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("br_flush", 1'b0, 1'b0, NOP_OP, 1'b1, 1'b0, 3);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("br_after", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 4);

    // Not-taken branch, then a stray br_done outside BR_WAIT
    tick(); drv(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, NOP_OP, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_c("bnt_issue", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 4);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_c("bnt_done", 1'b0, 1'b0, NOP_OP, 1'b0, 1'b0, 4);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_c("bnt_next", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 5);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("stray_brdone", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 5);

    // Store with delayed mem_ready
    tick(); mem_issue(ST_OP, 1'b0, 5'd0);
    expect_c("st_issue", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 5);
    for (int i = 1; i <= ST_WAIT; i++) begin
      tick(); idle((i == ST_WAIT) ? 1'b1 : 1'b0);
      expect_c("st_wait", 1'b0, 1'b1, ST_OP, 1'b0, 1'b0, 5);
    end
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_c("st_done", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 5);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("stray_mrdy", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 5);

    // Load to x5 with dependent rs1
    tick(); mem_issue(LD_OP, 1'b1, 5'd5);
    expect_c("ld5_issue", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 5);
    tick(); alu(5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_c("ld5_wait", 1'b0, 1'b1, LD_OP, 1'b0, 1'b0, 5);
    tick(); alu(5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("ld5_hazard", 1'b0, 1'b0, NOP_OP, 1'b0, 1'b0, 6);
    tick(); alu(5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("ld5_issue2", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 7);

    // Load to x0: no load-use stall
    tick(); mem_issue(LD_OP, 1'b1, 5'd0);
    expect_c("ld0_issue", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 7);
    tick(); alu(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_c("ld0_wait", 1'b0, 1'b1, LD_OP, 1'b0, 1'b0, 7);
    tick(); alu(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("ld0_nostall", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 8);

    // Load to x7, dependent through rs2 (used, then unused)
    tick(); mem_issue(LD_OP, 1'b1, 5'd7);
    expect_c("ld7a_issue", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 8);
    tick(); alu(5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_c("ld7a_wait", 1'b0, 1'b1, LD_OP, 1'b0, 1'b0, 8);
    tick(); alu(5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("ld7a_hazard", 1'b0, 1'b0, NOP_OP, 1'b0, 1'b0, 9);
    tick(); alu(5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("ld7a_issue2", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 10);
    tick(); mem_issue(LD_OP, 1'b1, 5'd7);
    expect_c("ld7b_issue", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 10);
    tick(); alu(5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_c("ld7b_wait", 1'b0, 1'b1, LD_OP, 1'b0, 1'b0, 10);
    tick(); alu(5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_c("ld7b_ldwb_ok", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 11);
    tick(); alu(5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_c("ld7b_after", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 11);

`ifdef ISSUE_MEM_TIMEOUT_EN
    // Timeout abort after four MEM_WAIT cycles, then ready in the fourth cycle wins
    tick(); mem_issue(ST_OP, 1'b0, 5'd0);
    expect_c("to_issue", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 11);
    for (int i = 1; i <= 4; i++) begin
      tick(); idle(1'b0);
      expect_c("to_wait", 1'b0, 1'b1, ST_OP, 1'b0, 1'b0, 11);
    end
    tick(); idle(1'b0);
    expect_c("to_err", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b1, 11);
    tick(); idle(1'b0);
    expect_c("to_err_end", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 11);
    tick(); mem_issue(ST_OP, 1'b0, 5'd0);
    expect_c("tr_issue", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 11);
    for (int i = 1; i <= 4; i++) begin
      tick(); idle((i == 4) ? 1'b1 : 1'b0);
      expect_c("tr_wait", 1'b0, 1'b1, ST_OP, 1'b0, 1'b0, 11);
    end
    tick(); idle(1'b0);
    expect_c("tr_noerr", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 11);
`endif

    // Asynchronous reset in the middle of MEM_WAIT
    tick(); mem_issue(ST_OP, 1'b0, 5'd0);
    expect_c("rst_st_issue", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 11);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("rst_st_wait", 1'b0, 1'b1, ST_OP, 1'b0, 1'b0, 11);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    expect_c("rst_async", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 0);
    tick();
    rst_n = 1'b1;
    alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("rst_after1", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 0);
    tick(); alu(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("rst_after2", 1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 0);

    tick();
    idle(1'b0);
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
